mem_port_arbiter: RTL and testbench

- Arbitrates the single shared instruction/data memory port between the fetch stage (IF) and the memory stage (MEM) of the 5-stage pipeline.
- Sequences each access with a req/ready handshake.
- Buffers the returned instruction word and load data.
- Drives one global Stall that freezes all pipeline registers until both stages' accesses for the current cycle are complete.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access. Data goes first.
// Latency: at least one IDLE cycle plus one access cycle per request. Data and fetch together take 4 stall cycles.
// Backpressure: Stall holds the pipeline until all accesses for the cycle finish; waits on mem_ready, bounded by a watchdog.
//
// Ports: clk/rst (async active-low); IF side PCF, FetchReqF -> InstrF;
//        MEM side ALUResultM, WriteDataM, MemWriteM, ResultSrcM -> ReadDataM;
//        Stall to pipeline; mem_req/we/addr/wdata/rdata/ready to memory; mem_err sticky timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        FetchReqF,
    output logic [31:0] InstrF,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    output logic [31:0] ReadDataM,
    output logic        Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] INST = 2'd2;

    logic [1:0] state, state_nxt;
    logic       inst_valid, data_done;
    logic [7:0] wd_cnt;
    logic       is_load, data_need, data_ok, inst_ok;
    logic       timeout_hit, acc_done;

    assign is_load   = (ResultSrcM == 2'b01);
    assign data_need = MemWriteM | is_load;
    assign data_ok   = !data_need | data_done;
    assign inst_ok   = !FetchReqF | inst_valid;
    assign Stall     = !(data_ok & inst_ok);

    // The access is abandoned on the cycle the wait count would reach TIMEOUT.
    // It is treated as complete so that the pipeline cannot deadlock.
    assign timeout_hit = mem_req & !mem_ready & (wd_cnt == 8'(TIMEOUT - 1));
    assign acc_done    = mem_req & (mem_ready | timeout_hit);

    // Memory-side outputs depend only on the state and the held pipeline inputs.
    // They therefore stay stable for as long as the access waits.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        case (state)
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = MemWriteM;
                mem_addr  = {ALUResultM[31:2], 2'b00};
                mem_wdata = WriteDataM;
            end
            INST: begin
                mem_req  = 1'b1;
                mem_addr = {PCF[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_need && !data_done)
                    state_nxt = DATA;
                else if (FetchReqF && !inst_valid)
                    state_nxt = INST;
            end
            DATA, INST: begin
                if (acc_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            InstrF     <= 32'd0;
            ReadDataM  <= 32'd0;
            inst_valid <= 1'b0;
            data_done  <= 1'b0;
            mem_err    <= 1'b0;
            wd_cnt     <= 8'd0;
        end else begin
            state <= state_nxt;

            if (mem_req && !mem_ready && !timeout_hit)
                wd_cnt <= wd_cnt + 8'd1;
            else
                wd_cnt <= 8'd0;

            if (timeout_hit)
                mem_err <= 1'b1;

            // Pipeline advance. The completion sets below take priority,
            // although they can only occur while Stall is high.
            if (!Stall) begin
                data_done  <= 1'b0;
                inst_valid <= 1'b0;
            end

            if (state == DATA && acc_done) begin
                data_done <= 1'b1;
                if (mem_ready && is_load)
                    ReadDataM <= mem_rdata;
            end

            if (state == INST && acc_done) begin
                inst_valid <= 1'b1;
                if (mem_ready)
                    InstrF <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, ALUResultM, WriteDataM, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] InstrF, ReadDataM;
    logic        FetchReqF, MemWriteM, Stall, mem_req, mem_we, mem_ready, mem_err;
    logic [1:0]  ResultSrcM;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;
    acc_t sb_q[$];

    int  ready_delay = 0;
    bit  never_ready = 0;
    int  wait_cnt    = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .PCF(PCF), .FetchReqF(FetchReqF), .InstrF(InstrF),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ReadDataM(ReadDataM), .Stall(Stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'h00A00093;
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory responder and scoreboard. Both act on the falling edge.
    always @(negedge clk) begin
        if (mem_req) begin
            if (!never_ready && wait_cnt == ready_delay) begin
                mem_ready = 1'b1;
                mem_rdata = mem_model(mem_addr);
            end else begin
                mem_ready = 1'b0;
            end
            wait_cnt++;
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
        if (mem_req && mem_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: access addr=%h we=%b, none expected", mem_addr, mem_we);
            end else begin
                acc_t e;
                e = sb_q.pop_front();
                if (mem_addr !== e.addr || mem_we !== e.we || (e.we && mem_wdata !== e.wdata))
                    $display("FAIL sb_access: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                             mem_addr, mem_we, mem_wdata, e.addr, e.we, e.wdata);
                else
                    passes++;
            end
        end
    end

    task automatic idle_inputs();
        PCF = 32'd0; FetchReqF = 1'b0; ALUResultM = 32'd0; WriteDataM = 32'd0;
        MemWriteM = 1'b0; ResultSrcM = 2'b00;
    endtask

    // Counts falling edges with Stall high, starting at the next edge.
    task automatic count_stall(output int n);
        n = 0;
        @(negedge clk);
        while (Stall && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (Stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'd0 || InstrF !== 32'd0 ||
                ReadDataM !== 32'd0 || mem_err !== 1'b0)
                $display("FAIL reset_idle: Stall=%b req=%b addr=%h InstrF=%h RD=%h err=%b, want all 0",
                         Stall, mem_req, mem_addr, InstrF, ReadDataM, mem_err);
            else passes++;
        end
    endtask

    task automatic test_fetch_only();
        int n;
        ready_delay = 0;
        sb_q.push_back('{32'h100, 1'b0, 32'd0});
        @(posedge clk); #1;
        PCF = 32'h100; FetchReqF = 1'b1;
        count_stall(n);
        checks++;
        if (n !== 2) $display("FAIL fetch_stall_cycles: got %0d, want 2", n); else passes++;
        checks++;
        if (InstrF !== 32'h00A00093) $display("FAIL fetch_instr: got %h, want 00a00093", InstrF);
        else passes++;
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_load_fetch();
        int n;
        ready_delay = 0;
        sb_q.push_back('{32'h2004, 1'b0, 32'd0});
        sb_q.push_back('{32'h104, 1'b0, 32'd0});
        @(posedge clk); #1;
        ResultSrcM = 2'b01; ALUResultM = 32'h2006; PCF = 32'h104; FetchReqF = 1'b1;
        count_stall(n);
        checks++;
        if (n !== 4) $display("FAIL loadfetch_stall_cycles: got %0d, want 4", n); else passes++;
        checks++;
        if (ReadDataM !== mem_model(32'h2004))
            $display("FAIL load_data: got %h, want %h", ReadDataM, mem_model(32'h2004));
        else passes++;
        checks++;
        if (InstrF !== mem_model(32'h104))
            $display("FAIL loadfetch_instr: got %h, want %h", InstrF, mem_model(32'h104));
        else passes++;
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_store_wait();
        ready_delay = 3;
        sb_q.push_back('{32'h3000, 1'b1, 32'hDEADBEEF});
        @(posedge clk); #1;
        MemWriteM = 1'b1; ALUResultM = 32'h3000; WriteDataM = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1 || mem_req !== 1'b0) $display("FAIL store_first_cycle: Stall=%b req=%b, want 1/0", Stall, mem_req);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3000 || mem_wdata !== 32'hDEADBEEF || Stall !== 1'b1)
                $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wdata=%h Stall=%b, want 1 1 3000 deadbeef 1",
                         i, mem_req, mem_we, mem_addr, mem_wdata, Stall);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0 || mem_req !== 1'b0 || ReadDataM !== mem_model(32'h2004))
            $display("FAIL store_done: Stall=%b req=%b RD=%h, want 0 0 %h", Stall, mem_req, ReadDataM, mem_model(32'h2004));
        else passes++;
        @(posedge clk); #1 idle_inputs();
        ready_delay = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        ready_delay = 0;
        sb_q.push_back('{32'h0, 1'b0, 32'd0});
        sb_q.push_back('{32'h4, 1'b0, 32'd0});
        @(posedge clk); #1;
        PCF = 32'h0; FetchReqF = 1'b1;
        count_stall(n);
        checks++;
        if (n !== 2 || InstrF !== mem_model(32'h0))
            $display("FAIL b2b_first: stalls=%0d InstrF=%h, want 2 %h", n, InstrF, mem_model(32'h0));
        else passes++;
        @(posedge clk); #1 PCF = 32'h4;
        count_stall(n);
        checks++;
        if (n !== 2 || InstrF !== mem_model(32'h4))
            $display("FAIL b2b_second: stalls=%0d InstrF=%h, want 2 %h", n, InstrF, mem_model(32'h4));
        else passes++;
        @(posedge clk); #1 idle_inputs();
    endtask

    task automatic test_timeout();
        int n;
        never_ready = 1;
        @(posedge clk); #1;
        PCF = 32'h200; FetchReqF = 1'b1;
        count_stall(n);
        checks++;
        if (n !== 5) $display("FAIL timeout_stall_cycles: got %0d, want 5", n); else passes++;
        checks++;
        if (mem_err !== 1'b1 || mem_req !== 1'b0 || InstrF !== mem_model(32'h4))
            $display("FAIL timeout_state: err=%b req=%b InstrF=%h, want 1 0 %h", mem_err, mem_req, InstrF, mem_model(32'h4));
        else passes++;
        @(posedge clk); #1 idle_inputs();
        never_ready = 0;
        repeat (4) @(negedge clk);
        checks++;
        if (mem_err !== 1'b1) $display("FAIL timeout_sticky: err=%b, want 1", mem_err); else passes++;
    endtask

    task automatic test_reset_mid_data();
        ready_delay = 10;
        @(posedge clk); #1;
        ResultSrcM = 2'b01; ALUResultM = 32'h4000;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) $display("FAIL rstmid_pre: req=%b, want 1", mem_req); else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || dut.state !== 2'd0 || InstrF !== 32'd0 || ReadDataM !== 32'd0 || mem_err !== 1'b0)
            $display("FAIL rstmid: req=%b state=%0d InstrF=%h RD=%h err=%b, want all 0",
                     mem_req, dut.state, InstrF, ReadDataM, mem_err);
        else passes++;
        @(posedge clk); #1 idle_inputs();
        @(posedge clk); #1 rst = 1'b1;
        ready_delay = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (Stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL rstmid_after: Stall=%b req=%b, want 0 0", Stall, mem_req);
        else passes++;
    endtask

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        test_reset();
        test_fetch_only();
        test_load_fetch();
        test_store_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid_data();
        checks++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d accesses never seen, want 0", sb_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
